// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Purpose : CPU-side load/store unit with sub-word extract/extend and RMW stores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEn,
    output logic        MemReadEn,
    input  logic [31:0] MemReadData
);

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_DONE = 2'd1,
        ST_RMW_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_word;

    logic        w_req;
    logic        w_misaligned;
    logic        w_is_store;

    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            C_SZ_BYTE: f_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            C_SZ_HALF: f_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   f_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] wdata,
                                            input logic [1:0]  lane,
                                            input logic [1:0]  size);
        logic [31:0] m;
        m = word;
        if (size == C_SZ_BYTE) begin
            case (lane)
                2'd0:    m[7:0]   = wdata[7:0];
                2'd1:    m[15:8]  = wdata[7:0];
                2'd2:    m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            m[31:16] = wdata[15:0];
        end else begin
            m[15:0]  = wdata[15:0];
        end
        f_merge = m;
    endfunction

    assign w_req        = MemRead | MemWrite;
    assign w_is_store   = MemWrite;
    assign w_misaligned = ((Size == C_SZ_HALF) && Address[0])
                        || ((Size == C_SZ_WORD) && (Address[1:0] != 2'b00))
                        || (Size == 2'b11);

    assign MemAddress = {Address[31:2], 2'b00};

    // Handshake outputs are combinational so a request is seen in its own cycle.
    always_comb begin
        MemReadEn    = 1'b0;
        MemWriteEn   = 1'b0;
        Stall        = 1'b0;
        MemWriteData = WriteData;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !w_misaligned) begin
                        if (w_is_store && (Size == C_SZ_WORD)) begin
                            MemWriteEn = 1'b1;
                        end else begin
                            MemReadEn = 1'b1;
                            Stall     = 1'b1;
                        end
                    end
                end
                ST_RMW_WRITE: begin
                    MemWriteEn   = 1'b1;
                    MemWriteData = r_word;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            ReadData   <= 32'd0;
            Misaligned <= 1'b0;
            r_word     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_misaligned) begin
                            Misaligned <= 1'b1;
                            if (!w_is_store) begin
                                ReadData <= 32'd0;
                            end
                        end else if (w_is_store) begin
                            // Merge at capture so RMW_WRITE only replays the stored word.
                            if (Size != C_SZ_WORD) begin
                                r_word  <= f_merge(MemReadData, WriteData, Address[1:0], Size);
                                r_state <= ST_RMW_WRITE;
                            end
                        end else begin
                            ReadData <= f_extract(MemReadData, Address[1:0], Size, Unsigned);
                            r_state  <= ST_LOAD_DONE;
                        end
                    end
                end
                ST_LOAD_DONE: r_state <= ST_IDLE;
                ST_RMW_WRITE: r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Directed table-driven bench for load_store_unit with a word memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Misaligned;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEn;
    logic        MemReadEn;
    logic [31:0] MemReadData;

    logic [31:0] mem [0:15];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    int n_checks;
    int n_pass;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .Misaligned   (Misaligned),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWriteEn   (MemWriteEn),
        .MemReadEn    (MemReadEn),
        .MemReadData  (MemReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign MemReadData = mem[MemAddress[5:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (MemWriteEn)
            mem[MemAddress[5:2]] <= MemWriteData;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        int          cyc;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_re;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wd,
                                input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input int cyc, input logic exp_we,
                                input logic [31:0] exp_wd, input logic exp_re,
                                input logic [31:0] exp_rdata, input logic exp_mis);
        vec_t v;
        v.addr = addr; v.wd = wd; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.cyc = cyc; v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_re = exp_re;
        v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          cyc;
        logic        saw_we;
        logic        saw_re;
        logic [31:0] wd_seen;
        logic [31:0] ma;
        @(negedge clk);
        Address = v.addr; WriteData = v.wd; MemRead = v.rd; MemWrite = v.wr;
        Size = v.size; Unsigned = v.uns;
        cyc = 0; saw_we = 1'b0; saw_re = 1'b0; wd_seen = 32'd0;
        #1;
        ma = MemAddress;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            cyc++;
            if (MemWriteEn) begin
                saw_we  = 1'b1;
                wd_seen = MemWriteData;
            end
            if (MemReadEn) saw_re = 1'b1;
            if (!Stall) break;
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.cycles", id), cyc, v.cyc);
        chk($sformatf("v%0d.memaddr", id), ma, {v.addr[31:2], 2'b00});
        chk($sformatf("v%0d.we_seen", id), {31'd0, saw_we}, {31'd0, v.exp_we});
        if (v.exp_we)
            chk($sformatf("v%0d.wdata", id), wd_seen, v.exp_wd);
        chk($sformatf("v%0d.re_seen", id), {31'd0, saw_re}, {31'd0, v.exp_re});
        chk($sformatf("v%0d.rdata", id), ReadData, v.exp_rdata);
        chk($sformatf("v%0d.misaligned", id), {31'd0, Misaligned}, {31'd0, v.exp_mis});
    endtask

    vec_t vecs[20];

    initial begin
        n_checks = 0; n_pass = 0;
        pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'd0;
        rst_n = 1'b0;
        // A live request during reset must not reach the memory.
        Address = 32'h4; WriteData = 32'h0; MemRead = 1'b1; MemWrite = 1'b0;
        Size = 2'b10; Unsigned = 1'b0;

        for (int i = 0; i < 16; i++) preload(i[3:0], 32'd0);
        preload(4'd2, 32'h1122_3344);
        preload(4'd3, 32'h80FF_7F01);

        #1;
        chk("rst.memreaden", {31'd0, MemReadEn}, 32'd0);
        chk("rst.stall", {31'd0, Stall}, 32'd0);
        chk("rst.readdata", ReadData, 32'd0);
        chk("rst.misaligned", {31'd0, Misaligned}, 32'd0);
        MemWrite = 1'b1;
        #1;
        chk("rst.memwriteen", {31'd0, MemWriteEn}, 32'd0);

        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle.stall", {31'd0, Stall}, 32'd0);
        chk("idle.enables", {30'd0, MemReadEn, MemWriteEn}, 32'd0);

        //            addr      wd            rd wr sz    u  cyc we wd_exp        re rdata         mis
        vecs[0]  = mk(32'h04, 32'hAAAA_AAAA, 0, 1, 2'b10, 0, 1, 1, 32'hAAAA_AAAA, 0, 32'h0000_0000, 0);
        vecs[1]  = mk(32'h04, 32'h0,         1, 0, 2'b10, 0, 2, 0, 32'h0,         1, 32'hAAAA_AAAA, 0);
        vecs[2]  = mk(32'h0A, 32'h0000_00EE, 0, 1, 2'b00, 0, 2, 1, 32'h11EE_3344, 1, 32'hAAAA_AAAA, 0);
        vecs[3]  = mk(32'h0D, 32'h0,         1, 0, 2'b00, 0, 2, 0, 32'h0,         1, 32'h0000_007F, 0);
        vecs[4]  = mk(32'h0E, 32'h0,         1, 0, 2'b00, 0, 2, 0, 32'h0,         1, 32'hFFFF_FFFF, 0);
        vecs[5]  = mk(32'h0E, 32'h0,         1, 0, 2'b01, 1, 2, 0, 32'h0,         1, 32'h0000_80FF, 0);
        vecs[6]  = mk(32'h0E, 32'h0,         1, 0, 2'b01, 0, 2, 0, 32'h0,         1, 32'hFFFF_80FF, 0);
        vecs[7]  = mk(32'h0F, 32'h0,         1, 0, 2'b00, 0, 2, 0, 32'h0,         1, 32'hFFFF_FF80, 0);
        vecs[8]  = mk(32'h0C, 32'h0,         1, 0, 2'b00, 1, 2, 0, 32'h0,         1, 32'h0000_0001, 0);
        vecs[9]  = mk(32'h0C, 32'h0,         1, 0, 2'b01, 0, 2, 0, 32'h0,         1, 32'h0000_7F01, 0);
        vecs[10] = mk(32'h08, 32'hDEAD_BEEF, 0, 1, 2'b01, 0, 2, 1, 32'h11EE_BEEF, 1, 32'h0000_7F01, 0);
        vecs[11] = mk(32'h08, 32'h0,         1, 0, 2'b10, 0, 2, 0, 32'h0,         1, 32'h11EE_BEEF, 0);
        vecs[12] = mk(32'h05, 32'h0,         1, 0, 2'b01, 0, 1, 0, 32'h0,         0, 32'h0000_0000, 1);
        vecs[13] = mk(32'h0C, 32'h0,         1, 0, 2'b10, 0, 2, 0, 32'h0,         1, 32'h80FF_7F01, 1);
        vecs[14] = mk(32'h02, 32'h1234_5678, 0, 1, 2'b10, 0, 1, 0, 32'h0,         0, 32'h80FF_7F01, 1);
        vecs[15] = mk(32'h10, 32'h0000_0005, 1, 1, 2'b10, 0, 1, 1, 32'h0000_0005, 0, 32'h80FF_7F01, 1);
        vecs[16] = mk(32'h10, 32'h0,         1, 0, 2'b11, 0, 1, 0, 32'h0,         0, 32'h0000_0000, 1);
        vecs[17] = mk(32'h13, 32'hABCD_EF12, 0, 1, 2'b00, 0, 2, 1, 32'h1200_0005, 1, 32'h0000_0000, 1);
        vecs[18] = mk(32'h10, 32'h0,         1, 0, 2'b10, 0, 2, 0, 32'h0,         1, 32'h1200_0005, 1);
        vecs[19] = mk(32'h13, 32'h0,         1, 0, 2'b00, 0, 2, 0, 32'h0,         1, 32'h0000_0012, 1);

        for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

        // Reset landing in RMW_WRITE must drop the merged write.
        @(negedge clk);
        Address = 32'h08; WriteData = 32'h0000_0077; MemRead = 1'b0; MemWrite = 1'b1;
        Size = 2'b00; Unsigned = 1'b0;
        #1;
        chk("rmwrst.stall_idle", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmwrst.we", {31'd0, MemWriteEn}, 32'd0);
        chk("rmwrst.stall", {31'd0, Stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("rmwrst.readdata", ReadData, 32'd0);
        chk("rmwrst.misaligned", {31'd0, Misaligned}, 32'd0);
        chk("rmwrst.mem", mem[2], 32'h11EE_BEEF);
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n = 1'b1;
        run_vec(mk(32'h08, 32'h0, 1, 0, 2'b10, 0, 2, 0, 32'h0, 1, 32'h11EE_BEEF, 0), 20);

        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be none; all widths are fixed at 32-bit data and 32-bit byte address.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 Address  in  32  CPU byte address.
REQ-005 WriteData  in  32  CPU store data; sub-word stores use low bits.
REQ-006 MemRead  in  1  CPU load request, held until Stall=0.
REQ-007 MemWrite  in  1  CPU store request, held until Stall=0.
REQ-008 Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-010 ReadData  out  32  registered load result, extended.
REQ-011 Stall  out  1  CPU must hold request and PC while 1.
REQ-012 Misaligned  out  1  sticky misaligned/illegal-access flag.
REQ-013 MemAddress  out  32  word address to DataMemory, bits [1:0] always 00.
REQ-014 MemWriteData  out  32  word to DataMemory.
REQ-015 MemWriteEn  out  1  DataMemory write strobe, written on rising edge.
REQ-016 MemReadEn  out  1  DataMemory read enable.
REQ-017 MemReadData  in  32  DataMemory word, combinational from MemAddress/MemReadEn.

Function
REQ-018 States SHALL be IDLE, LOAD_DONE, RMW_WRITE; encoding is free.
REQ-019 MemAddress SHALL be {Address[31:2],2'b00} in every state.
REQ-020 Request with MemWrite=1 SHALL be a store regardless of MemRead (store priority).
REQ-021 Misaligned access: Size=01 with Address[0]=1, Size=10 with Address[1:0]!=00, or Size=11.
REQ-022 Misaligned request in IDLE SHALL issue no memory enable, Stall=0, set Misaligned on that edge; a load also clears ReadData to 0.
REQ-023 Load in IDLE: MemReadEn=1, Stall=1; capture MemReadData on edge; go LOAD_DONE.
REQ-024 LOAD_DONE: Stall=0, ReadData valid (registered on the IDLE edge), enables 0; next edge go IDLE. Load latency 2 cycles.
REQ-025 Load extract little-endian: byte lane Address[1:0] (lane 0 = bits 7:0); halfword lane Address[1], bits [16*lane+15:16*lane].
REQ-026 Extension: bit 7 (byte) or bit 15 (half) replicated when Unsigned=0, zeros when 1; word loads unchanged.
REQ-027 Aligned word store in IDLE: MemWriteEn=1, MemWriteData=WriteData, Stall=0, stay IDLE; latency 1 cycle.
REQ-028 Sub-word store in IDLE: MemReadEn=1, Stall=1, capture MemReadData; go RMW_WRITE.
REQ-029 RMW_WRITE: MemWriteEn=1, MemWriteData = captured word with target lane replaced by WriteData[7:0] or [15:0]; Stall=0; next edge IDLE.
REQ-030 ReadData SHALL hold its value until the next load completes or a misaligned load clears it; stores never change it.
REQ-031 No request in IDLE: all enables 0, Stall=0.
REQ-032 Back-to-back requests SHALL be accepted in the IDLE cycle immediately after LOAD_DONE or RMW_WRITE; no bubble beyond those states.
REQ-033 Misaligned SHALL stay 1 until reset; it does not block later accesses.

Reset
REQ-034 rst_n=0 at a rising edge: state IDLE, ReadData=0, Misaligned=0, captured word=0.
REQ-035 While rst_n=0, MemWriteEn, MemReadEn, Stall SHALL be 0 combinationally, in any state.
REQ-036 Reset in LOAD_DONE or RMW_WRITE SHALL abort; the pending merged write is never issued.

Verification
REQ-037 Word store 0xAAAA_AAAA @0x4 then word load @0x4 -> store 1 cycle with MemWriteEn=1 and MemAddress=0x4; load Stall=1 then ReadData=0xAAAA_AAAA.
REQ-038 Memory @0x8=0x1122_3344, byte store 0xEE @0xA -> Stall 1 cycle, then MemWriteData=0x11EE_3344, MemWriteEn=1.
REQ-039 Memory @0x8=0x80FF_7F01: byte load @0x9 Unsigned=0 -> 0x0000_007F; byte load @0xA Unsigned=0 -> 0xFFFF_FFFF; halfword load @0xA Unsigned=1 -> 0x0000_80FF.
REQ-040 Halfword load @0x5 -> no MemReadEn, Stall=0, Misaligned=1 sticky, ReadData=0; next aligned load completes normally.
REQ-041 rst_n=0 during RMW_WRITE of byte store -> MemWriteEn never asserted, memory word unchanged, state IDLE, ReadData=0.
REQ-042 MemRead=MemWrite=1 word @0x10, WriteData=0x5 -> treated as store: MemWriteEn=1, ReadData unchanged.
